cpu6_shftseq: RTL and testbench
===============================

# cpu6_shftseq

Iterative shift sequencer for the cpu6 execute stage. It takes the decoder's `shft_en`, `shft_lr` and `shft_la` controls with the rs1 value and shift amount, and shifts one bit position per clock. It stalls the pipeline until the result is ready, then presents the result for exactly one cycle. It replaces a 32-bit barrel shifter with a 32-bit register, a 5-bit counter and a small state machine.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `SHAMT_W`, 5, shift-amount width; equals log2(`XLEN`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `shft_en`  in  1  decoded instruction in execute is a shift (SLL/SRL/SRA/SLLI/SRLI/SRAI); held high until `done`.
- `shft_lr`  in  1  0 = shift left, 1 = shift right.
- `shft_la`  in  1  0 = logical, 1 = arithmetic (meaningful for right shifts only).
- `src`  in  XLEN  operand (rs1 value).
- `shamt`  in  SHAMT_W  shift amount (rs2[4:0] or the immediate shamt).
- `flush`  in  1  pipeline flush (branch/jump/trap/mret); aborts any operation in progress.
- `stall`  out  1  freezes fetch/decode/execute while the shift is incomplete.
- `done`  out  1  one-cycle strobe; `result` is valid in this cycle.
- `result`  out  XLEN  shifted value.

## Operation
- States: IDLE, RUN, DONE.
- Registers: `data` (XLEN), `cnt` (SHAMT_W), `lr`, `la`, captured at accept.
- Accept: in IDLE with `shft_en`=1 and `flush`=0, at the edge:
  - load `data`=`src`, `cnt`=`shamt`, `lr`=`shft_lr`, `la`=`shft_la`;
  - next state is DONE if `shamt`==0, else RUN.
- RUN, at each edge:
  - left: `data` = {`data`[XLEN-2:0], 0};
  - right: `data` = {fill, `data`[XLEN-1:1]}, where fill = `la` & `data`[XLEN-1];
  - `cnt` decrements by 1;
  - when `cnt`==1 before the edge, next state is DONE.
- DONE: `done`=1 and `result`=`data` for one cycle; the next state is always IDLE, even though `shft_en` is still high this cycle. The operation is never restarted from DONE.
- `stall` = `shft_en` & ~`done` (combinational). It is high in the request cycle and all RUN cycles, and low in DONE so the pipeline advances.
- `result` continuously drives `data`. It holds its value after DONE until the next accept. Consumers must qualify it with `done`.
- `shft_la`=1 with `shft_lr`=0 behaves as a logical left shift.
- Inputs are sampled only at accept. Later changes to `src`, `shamt` or the control bits during RUN are ignored.
- `flush`=1 at any edge: next state is IDLE and no `done` is produced; `data` and `cnt` are don't-care. Flush has priority over accept and over the RUN→DONE transition.
- `flush` with `shft_en` in the same IDLE cycle: no accept.
- Reset (`resetn`=0 at an edge), including mid-operation: state IDLE, `data`=0, `cnt`=0, `lr`=0, `la`=0. Reset has priority over `flush` and `shft_en`.

## Timing
- Cycle 0 is the first cycle with `shft_en`=1 in IDLE. `done` is high in cycle `shamt`+1.
  - `shamt`=0 gives `done` in cycle 1; `shamt`=31 gives `done` in cycle 32.
- `stall` is high in cycles 0..`shamt` and low in cycle `shamt`+1.
- Back-to-back shifts: after DONE, the next shift request is accepted in the following IDLE cycle, with no extra bubble beyond that IDLE cycle.
- Outputs after reset: `stall` = `shft_en` (combinational), `done`=0, `result`=0.
- No combinational path from `src` or `shamt` to any output. `stall` depends only on `shft_en` and state.

## Test plan
- SLL: `src`=0x0000_0001, `shamt`=31, `shft_lr`=0 -> `stall` high in cycles 0..31; `done` in cycle 32 with `result`=0x8000_0000.
- SRA vs SRL: `src`=0x8000_0000, `shamt`=4 -> with `shft_la`=1, `result`=0xF800_0000; with `shft_la`=0, `result`=0x0800_0000; `done` in cycle 5 in both cases.
- Zero shift: `src`=0xDEAD_BEEF, `shamt`=0 -> `done` in cycle 1, `result`=0xDEAD_BEEF, `stall` high only in cycle 0.
- Flush mid-RUN: SRL with `shamt`=10, `flush` pulsed in cycle 3 -> IDLE in cycle 4; `done` never asserts; a new SLL of 0x3 by 2 then yields 0x0000_000C three cycles after its accept (`done` in its cycle 3).
- Reset mid-RUN: `resetn` low at cycle 5 of a 20-cycle shift -> `done`=0 and `result`=0 afterwards; no spurious `done`.
- Back-to-back: SLL 0x1 by 1, then SRA 0xFFFF_FF00 by 8 -> `done` pulses carry 0x0000_0002, then 0xFFFF_FFFF. The second accept occurs in the IDLE cycle after the first DONE, and input changes during RUN are ignored.

Source files
------------

// File: rtl/cpu6_shftseq.sv
// cpu6_shftseq: iterative one-bit-per-clock shifter for the execute stage.
// Holds the pipeline with stall until the shift completes, then raises done
// for a single cycle with the shifted value on result.
module cpu6_shftseq #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               shft_en,
    input  logic               shft_lr,
    input  logic               shft_la,
    input  logic [XLEN-1:0]    src,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               stall,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [XLEN-1:0]    data, data_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic               lr, lr_nxt;
    logic               la, la_nxt;

    // State and datapath registers; reset dominates everything else.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            lr    <= 1'b0;
            la    <= 1'b0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            cnt   <= cnt_nxt;
            lr    <= lr_nxt;
            la    <= la_nxt;
        end
    end

    // Next-state and datapath update; flush overrides any transition.
    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        cnt_nxt   = cnt;
        lr_nxt    = lr;
        la_nxt    = la;
        case (state)
            IDLE: begin
                // Operands are captured only here; later input changes are ignored.
                if (shft_en && !flush) begin
                    data_nxt  = src;
                    cnt_nxt   = shamt;
                    lr_nxt    = shft_lr;
                    la_nxt    = shft_la;
                    state_nxt = (shamt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (lr)
                    // Arithmetic fill only applies to right shifts.
                    data_nxt = {la & data[XLEN-1], data[XLEN-1:1]};
                else
                    data_nxt = {data[XLEN-2:0], 1'b0};
                cnt_nxt = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                // Always drop back to IDLE even though shft_en is still high,
                // so the same instruction is never shifted twice.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    assign done   = (state == DONE);
    assign stall  = shft_en & ~done;
    assign result = data;

endmodule

// File: tb/tb_cpu6_shftseq.sv
// Directed bench for cpu6_shftseq: latency, stall profile, results,
// flush/reset aborts and back-to-back issue.
module tb_cpu6_shftseq;

    logic        clk;
    logic        resetn;
    logic        shft_en;
    logic        shft_lr;
    logic        shft_la;
    logic [31:0] src;
    logic [4:0]  shamt;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vectors    = 0;
    int miscompares = 0;

    cpu6_shftseq #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .shft_en (shft_en),
        .shft_lr (shft_lr),
        .shft_la (shft_la),
        .src     (src),
        .shamt   (shamt),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs may be driven right after, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a shift in the current cycle (cycle 0) and follow it to its done
    // cycle. Returns with the bench sitting in the done cycle.
    task automatic do_shift(input string tag, input logic [31:0] s, input logic [4:0] sh,
                            input logic lr_i, input logic la_i, input logic [31:0] exp);
        int cyc;
        int bad_stall;
        src = s; shamt = sh; shft_lr = lr_i; shft_la = la_i; shft_en = 1'b1;
        #1;
        cyc = 0;
        bad_stall = 0;
        while (cyc < 40 && done !== 1'b1) begin
            if (stall !== 1'b1) bad_stall++;
            tick();
            if (cyc == 0) begin
                // Operands must be ignored once accepted.
                src = ~s; shamt = ~sh; shft_lr = ~lr_i; shft_la = ~la_i;
            end
            #1;
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(sh) + 32'd1);
        chk({tag, "_stall_low_before_done"}, 32'(bad_stall), 32'd0);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        int n;
        resetn = 1'b0; shft_en = 1'b0; shft_lr = 1'b0; shft_la = 1'b0;
        src = 32'h0; shamt = 5'd0; flush = 1'b0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_stall_en0", {31'd0, stall}, 32'd0);
        shft_en = 1'b1;
        #1;
        chk("rst_stall_follows_en", {31'd0, stall}, 32'd1);
        tick();
        shft_en = 1'b0;
        resetn = 1'b1;
        tick();

        // SLL 1 by 31
        do_shift("sll31", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
        tick(); shft_en = 1'b0;
        #1;
        chk("result_hold_after_done", result, 32'h8000_0000);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        tick();

        // SRA vs SRL by 4
        do_shift("sra4", 32'h8000_0000, 5'd4, 1'b1, 1'b1, 32'hF800_0000);
        tick(); shft_en = 1'b0; tick();
        do_shift("srl4", 32'h8000_0000, 5'd4, 1'b1, 1'b0, 32'h0800_0000);
        tick(); shft_en = 1'b0; tick();

        // Left shift with la=1 is still logical
        do_shift("sll_la", 32'h8000_0003, 5'd1, 1'b0, 1'b1, 32'h0000_0006);
        tick(); shft_en = 1'b0; tick();

        // Zero shift
        do_shift("zero", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        tick(); shft_en = 1'b0; tick();

        // Flush together with a request in IDLE: no accept, data untouched
        src = 32'h1234_5678; shamt = 5'd0; shft_lr = 1'b0; shft_la = 1'b0;
        shft_en = 1'b1; flush = 1'b1;
        tick(); shft_en = 1'b0; flush = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            #1; if (done === 1'b1) n++;
            tick();
        end
        chk("flush_idle_no_done", 32'(n), 32'd0);
        chk("flush_idle_no_load", result, 32'hDEAD_BEEF);

        // Flush mid-RUN (SRL by 10, flush in cycle 3)
        src = 32'hFFFF_0000; shamt = 5'd10; shft_lr = 1'b1; shft_la = 1'b0; shft_en = 1'b1;
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; shft_en = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            #1; if (done === 1'b1) n++;
            tick();
        end
        chk("flush_run_no_done", 32'(n), 32'd0);
        do_shift("after_flush", 32'h0000_0003, 5'd2, 1'b0, 1'b0, 32'h0000_000C);
        tick(); shft_en = 1'b0; tick();

        // Reset mid-RUN at cycle 5 of a 20-cycle shift
        src = 32'hA5A5_A5A5; shamt = 5'd20; shft_lr = 1'b1; shft_la = 1'b1; shft_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1; shft_en = 1'b0;
        #1;
        chk("midrst_result", result, 32'h0);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            #1; if (done === 1'b1) n++;
            tick();
        end
        chk("midrst_no_done", 32'(n), 32'd0);
        chk("midrst_result_hold", result, 32'h0);

        // Back-to-back: second request in the IDLE cycle right after DONE
        do_shift("b2b_sll1", 32'h0000_0001, 5'd1, 1'b0, 1'b0, 32'h0000_0002);
        tick();
        do_shift("b2b_sra8", 32'hFFFF_FF00, 5'd8, 1'b1, 1'b1, 32'hFFFF_FFFF);
        tick(); shft_en = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
